cv32e40p_obi_mem_responder: RTL

OBI responder end of the core's data-memory interface: accepts req/addr/we/be/wdata from the core, grants and returns in-order rvalid/rdata after a fixed latency. Backs requests with a word-addressed byte-enable RAM. Used as the data (or instruction) memory in the cv32e40p_top integration bench and FPGA bring-up. An external stall input throttles grant so the bench can exercise core wait states.

---
 rtl/cv32e40p_obi_pkg.sv | 17 +
 rtl/cv32e40p_obi_resp_pipe.sv | 22 ++
 rtl/cv32e40p_obi_mem_responder.sv | 62 ++++++
 3 files changed

// File: rtl/cv32e40p_obi_pkg.sv
// cv32e40p_obi_pkg: shared response type, byte-enable width and parameter range checks for the OBI memory responder.
package cv32e40p_obi_pkg;
  localparam int OBI_BE_W = 4;
  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
  } obi_resp_t;
  function automatic bit lat_ok(int lat);
    return lat >= 1 && lat <= 4;
  endfunction
  function automatic bit outstanding_ok(int n);
    return n >= 1 && n <= 4;
  endfunction
  function automatic bit addr_width_ok(int w);
    return w >= 1 && w <= 29;
  endfunction
endpackage

// File: rtl/cv32e40p_obi_resp_pipe.sv
// cv32e40p_obi_resp_pipe: fixed-depth shift register carrying {valid, rdata} from accept to the response port.
module cv32e40p_obi_resp_pipe
  import cv32e40p_obi_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  obi_resp_t resp_i,
  output obi_resp_t resp_o
);
  obi_resp_t [LAT-1:0] stage_q, stage_d;
  always_comb begin
    stage_d[0] = resp_i;
    for (int i = 1; i < LAT; i++) stage_d[i] = stage_q[i-1];
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stage_q <= '0;
    else         stage_q <= stage_d;
  end
  assign resp_o = stage_q[LAT-1];
endmodule

// File: rtl/cv32e40p_obi_mem_responder.sv
// cv32e40p_obi_mem_responder: OBI responder backed by a word-addressed byte-enable RAM,
// in-order responses after a fixed latency, outstanding-limited and externally stallable grant.
module cv32e40p_obi_mem_responder
  import cv32e40p_obi_pkg::*;
#(
  parameter int ADDR_WIDTH      = 12,
  parameter int RVALID_LAT      = 1,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  input  logic        gnt_stall_i,
  output logic [2:0]  outstanding_o
);
  if (!(lat_ok(RVALID_LAT) && outstanding_ok(MAX_OUTSTANDING) && addr_width_ok(ADDR_WIDTH))) begin : g_bad_param
    $error("cv32e40p_obi_mem_responder: parameter out of range");
  end
  logic [31:0]           mem_q [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic                  accept;
  logic [2:0]            outstanding_q, outstanding_d;
  obi_resp_t             resp_in, resp_out;
  logic                  unused_addr;
  assign unused_addr = ^{addr_i[31:ADDR_WIDTH+2], addr_i[1:0]};
  // Upper address bits are dropped so the RAM aliases modulo its depth.
  always_comb begin
    idx           = addr_i[ADDR_WIDTH+1:2];
    gnt_o         = req_i & ~gnt_stall_i & (outstanding_q < 3'(MAX_OUTSTANDING));
    accept        = req_i & gnt_o;
    resp_in.valid = accept;
    resp_in.rdata = (accept & ~we_i) ? mem_q[idx] : '0;
    outstanding_d = outstanding_q + 3'(accept) - 3'(resp_out.valid);
  end
  always_ff @(posedge clk_i) begin
    if (accept & we_i)
      for (int k = 0; k < OBI_BE_W; k++)
        if (be_i[k]) mem_q[idx][8*k +: 8] <= wdata_i[8*k +: 8];
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) outstanding_q <= '0;
    else         outstanding_q <= outstanding_d;
  end
  cv32e40p_obi_resp_pipe #(.LAT(RVALID_LAT)) u_resp_pipe (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .resp_i (resp_in),
    .resp_o (resp_out)
  );
  assign rvalid_o      = resp_out.valid;
  assign rdata_o       = resp_out.rdata;
  assign outstanding_o = outstanding_q;
  a_outstanding_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    outstanding_q <= 3'(MAX_OUTSTANDING) && !(resp_out.valid && outstanding_q == '0));
endmodule
